// File: rtl/cpu6_bus_pkg.sv
// cpu6_bus_pkg
// Shared constants and types for the CPU6 bus responder:
//   - memory-map addresses (RAM window top, console status/control, console data)
//   - status-byte bit positions and the master-reset control code
//   - serializer state encoding
//   - status_byte(): assembles the console status byte
package cpu6_bus_pkg;

    localparam logic [15:0] RAM_TOP   = 16'h7FFF;
    localparam logic [15:0] ACIA_STAT = 16'hF200;
    localparam logic [15:0] ACIA_DATA = 16'hF201;

    localparam int TDRE_BIT = 1;
    localparam int OVR_BIT  = 5;

    localparam logic [1:0] MRESET_CODE = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Every bit other than TDRE and OVR reads as zero.
    function automatic logic [7:0] status_byte(input logic tdre, input logic ovr);
        logic [7:0] s;
        s           = 8'h00;
        s[TDRE_BIT] = tdre;
        s[OVR_BIT]  = ovr;
        return s;
    endfunction

endpackage

// File: rtl/cpu6_uart_tx.sv
// cpu6_uart_tx
// Console transmitter: a small byte FIFO feeding an 8N1 serializer.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   push, push_data  enqueue push_data (dropped and OVR set if FIFO full)
//   flush            master reset: empty FIFO, clear OVR, abort any frame
//   full             FIFO full
//   ovr              sticky overflow flag
//   uart_tx          registered serial line, idle high
//   busy             serializer active or FIFO non-empty
module cpu6_uart_tx
    import cpu6_bus_pkg::*;
#(
    parameter int FIFO_AW      = 2,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       flush,
    output logic       full,
    output logic       ovr,
    output logic       uart_tx,
    output logic       busy
);

    localparam int PW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(CLKS_PER_BIT);

    logic [7:0]    fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovr_q, ovr_d;
    tx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic empty;
    logic do_push;
    logic do_pop;
    logic timer_last;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign do_push    = push && !full && !flush;
    assign do_pop     = (state_q == TX_IDLE) && !empty && !flush;
    assign timer_last = (timer_q == TW'(CLKS_PER_BIT - 1));

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(do_push);
        rd_ptr_d  = rd_ptr_q + PW'(do_pop);
        // A full-FIFO push overflows even if a pop frees a slot at the same edge.
        ovr_d     = ovr_q | (push & full);
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        case (state_q)
            TX_IDLE: begin
                if (do_pop) begin
                    state_d   = TX_START;
                    shift_d   = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
                    tx_d      = 1'b0;
                    timer_d   = '0;
                    bit_cnt_d = 3'd0;
                end
            end
            TX_START: begin
                if (timer_last) begin
                    state_d = TX_DATA;
                    timer_d = '0;
                    tx_d    = shift_q[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            TX_DATA: begin
                if (timer_last) begin
                    timer_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Present the next bit from the pre-shift value so the line
                        // changes exactly on the bit boundary.
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            TX_STOP: begin
                if (timer_last) begin
                    state_d = TX_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ovr_d     = 1'b0;
            state_d   = TX_IDLE;
            timer_d   = '0;
            bit_cnt_d = 3'd0;
            tx_d      = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovr_q     <= 1'b0;
            state_q   <= TX_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovr_q     <= ovr_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // FIFO storage carries no reset; the pointers define its contents.
    always_ff @(posedge clock) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
        end
    end

    assign ovr     = ovr_q;
    assign uart_tx = tx_q;
    assign busy    = (state_q != TX_IDLE) || !empty;

endmodule

// File: rtl/cpu6_bus_responder.sv
// cpu6_bus_responder
// Target side of the CPU6 memory bus: mirrored scratch RAM in 0x0000-0x7FFF,
// console status/control at 0xF200 and TX data at 0xF201, 0xFF elsewhere.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   address_bus      CPU address
//   write_en_bus     write strobe for data_out_bus at this edge
//   data_out_bus     CPU write data
//   data_in_bus      registered read data (1 clock after address)
//   uart_tx          console serial line, idle high
//   tx_busy          transmitter active or FIFO non-empty
module cpu6_bus_responder
    import cpu6_bus_pkg::*;
#(
    parameter int RAM_AW       = 12,
    parameter int FIFO_AW      = 2,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] address_bus,
    input  logic        write_en_bus,
    input  logic [7:0]  data_out_bus,
    output logic [7:0]  data_in_bus,
    output logic        uart_tx,
    output logic        tx_busy
);

    logic [7:0]        ram [2**RAM_AW];
    logic [7:0]        ram_rd_q;
    logic              sel_ram_q, sel_ram_d;
    logic [7:0]        other_rd_q, other_rd_d;

    logic              in_ram;
    logic              is_stat;
    logic              is_data;
    logic [RAM_AW-1:0] ram_idx;
    logic              tx_push;
    logic              tx_flush;
    logic              tx_full;
    logic              tx_ovr;

    assign in_ram   = (address_bus <= RAM_TOP);
    assign is_stat  = (address_bus == ACIA_STAT);
    assign is_data  = (address_bus == ACIA_DATA);
    // Upper address bits inside the RAM window are ignored, giving the mirrors.
    assign ram_idx  = address_bus[RAM_AW-1:0];
    assign tx_push  = write_en_bus && is_data;
    assign tx_flush = write_en_bus && is_stat && (data_out_bus[1:0] == MRESET_CODE);

    // Read-before-write: a same-edge write and read of one address returns the old byte.
    always_ff @(posedge clock) begin
        if (write_en_bus && in_ram) begin
            ram[ram_idx] <= data_out_bus;
        end
        ram_rd_q <= ram[ram_idx];
    end

    always_comb begin
        sel_ram_d = in_ram;
        if (is_stat) begin
            other_rd_d = status_byte(!tx_full, tx_ovr);
        end else if (is_data) begin
            other_rd_d = 8'h00;
        end else begin
            other_rd_d = 8'hFF;
        end
    end

    // Non-RAM read data is registered alongside the RAM select so the reset
    // value 0xFF appears immediately without needing to reset the RAM port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_ram_q  <= 1'b0;
            other_rd_q <= 8'hFF;
        end else begin
            sel_ram_q  <= sel_ram_d;
            other_rd_q <= other_rd_d;
        end
    end

    assign data_in_bus = sel_ram_q ? ram_rd_q : other_rd_q;

    cpu6_uart_tx #(
        .FIFO_AW      (FIFO_AW),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (tx_push),
        .push_data (data_out_bus),
        .flush     (tx_flush),
        .full      (tx_full),
        .ovr       (tx_ovr),
        .uart_tx   (uart_tx),
        .busy      (tx_busy)
    );

endmodule

// File: tb/tb_cpu6_bus_responder.sv
// tb_cpu6_bus_responder
// Drives one bus transaction per clock and compares read data, serial line and
// busy flag every cycle against a queue-based reference of the memory map,
// the TX FIFO and the expected line waveform.
module tb_cpu6_bus_responder;

    localparam int RAM_AW = 12;
    localparam int DEPTH  = 4;
    localparam int CPB    = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] address_bus;
    logic        write_en_bus;
    logic [7:0]  data_out_bus;
    logic [7:0]  data_in_bus;
    logic        uart_tx;
    logic        tx_busy;

    always #5 clock = ~clock;

    cpu6_bus_responder #(
        .RAM_AW       (RAM_AW),
        .FIFO_AW      (2),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .address_bus  (address_bus),
        .write_en_bus (write_en_bus),
        .data_out_bus (data_out_bus),
        .data_in_bus  (data_in_bus),
        .uart_tx      (uart_tx),
        .tx_busy      (tx_busy)
    );

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    // Reference state
    logic [7:0] mem_m   [1 << RAM_AW];
    bit         valid_m [1 << RAM_AW];
    logic [7:0] fifo_m [$];
    bit         line_m [$];
    bit         ovr_m;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        line_m.delete();
        ovr_m = 1'b0;
    endtask

    function automatic logic [7:0] status_m();
        logic [7:0] s;
        s = 8'h00;
        if (fifo_m.size() < DEPTH) s[1] = 1'b1;
        if (ovr_m) s[5] = 1'b1;
        return s;
    endfunction

    // One frame on the line: start, 8 data bits LSB first, stop, then the
    // single idle clock that separates frames.
    task automatic queue_frame(input logic [7:0] b);
        for (int k = 0; k < CPB; k++) line_m.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < CPB; k++) line_m.push_back(b[i]);
        for (int k = 0; k < CPB; k++) line_m.push_back(1'b1);
        line_m.push_back(1'b1);
    endtask

    task automatic step(input logic [15:0] a, input logic we, input logic [7:0] d);
        logic [7:0] exp_rd;
        bit         known;
        bit         can_pop;
        bit         was_full;
        logic [7:0] b;
        logic       exp_line;
        logic       exp_busy;
        address_bus  = a;
        write_en_bus = we;
        data_out_bus = d;
        known  = 1'b1;
        exp_rd = 8'hFF;
        b      = 8'h00;
        if (a <= 16'h7FFF) begin
            known  = valid_m[a[RAM_AW-1:0]];
            exp_rd = mem_m[a[RAM_AW-1:0]];
        end else if (a == 16'hF200) begin
            exp_rd = status_m();
        end else if (a == 16'hF201) begin
            exp_rd = 8'h00;
        end
        if (we && a == 16'hF200 && d[1:0] == 2'b11) begin
            model_reset();
        end else begin
            can_pop  = (line_m.size() == 0) && (fifo_m.size() > 0);
            was_full = (fifo_m.size() == DEPTH);
            if (can_pop) b = fifo_m.pop_front();
            if (we && a == 16'hF201) begin
                if (was_full) ovr_m = 1'b1;
                else fifo_m.push_back(d);
            end
            if (can_pop) queue_frame(b);
        end
        if (we && a <= 16'h7FFF) begin
            mem_m[a[RAM_AW-1:0]]   = d;
            valid_m[a[RAM_AW-1:0]] = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        cycle++;
        exp_line = (line_m.size() > 0) ? line_m.pop_front() : 1'b1;
        exp_busy = (line_m.size() > 0) || (fifo_m.size() > 0);
        if (known) check8("data_in_bus", data_in_bus, exp_rd);
        check1("uart_tx", uart_tx, exp_line);
        check1("tx_busy", tx_busy, exp_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h8000, 1'b0, 8'h00);
    endtask

    // Called at a negedge: assert reset in the middle of the low phase and
    // check the outputs before any clock edge arrives.
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check8("async_rst data_in_bus", data_in_bus, 8'hFF);
        check1("async_rst uart_tx", uart_tx, 1'b1);
        check1("async_rst tx_busy", tx_busy, 1'b0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int r;
        logic [15:0] ra;

        reset_n      = 1'b0;
        address_bus  = 16'h8000;
        write_en_bus = 1'b0;
        data_out_bus = 8'h00;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check8("por data_in_bus", data_in_bus, 8'hFF);
        check1("por uart_tx", uart_tx, 1'b1);
        check1("por tx_busy", tx_busy, 1'b0);
        reset_n = 1'b1;

        // Reset from a non-0xFF read value, then status
        step(16'h0010, 1'b1, 8'h00);
        step(16'h0010, 1'b0, 8'h00);
        async_reset();
        step(16'hF200, 1'b0, 8'h00);

        // RAM, mirror, unmapped, data-register read, same-edge write/read
        step(16'h0123, 1'b1, 8'h5A);
        step(16'h0123, 1'b0, 8'h00);
        step(16'h1123, 1'b0, 8'h00);
        step(16'h9000, 1'b0, 8'h00);
        step(16'hF201, 1'b0, 8'h00);
        step(16'h0123, 1'b1, 8'h77);
        step(16'h7123, 1'b0, 8'h00);
        step(16'hF202, 1'b1, 8'h33);
        step(16'h0123, 1'b0, 8'h00);

        // Single frame
        step(16'hF201, 1'b1, 8'hA5);
        idle(170);

        // Overflow: six back-to-back writes, five frames go out
        for (int i = 1; i <= 6; i++) step(16'hF201, 1'b1, 8'(i));
        step(16'hF200, 1'b0, 8'h00);
        idle(5 * 161 + 10);
        step(16'hF200, 1'b0, 8'h00);
        step(16'hF200, 1'b1, 8'h03);
        step(16'hF200, 1'b0, 8'h00);

        // Master reset mid-DATA with two bytes queued; non-reset control ignored
        step(16'hF201, 1'b1, 8'h11);
        step(16'hF201, 1'b1, 8'h22);
        step(16'hF201, 1'b1, 8'h33);
        idle(40);
        step(16'hF200, 1'b1, 8'h02);
        step(16'hF200, 1'b0, 8'h00);
        step(16'hF200, 1'b1, 8'h03);
        idle(200);
        step(16'hF200, 1'b0, 8'h00);

        // Asynchronous reset during data bit 3
        step(16'hF201, 1'b1, 8'hC3);
        idle(1 + CPB + 3 * CPB + 5);
        async_reset();
        idle(200);
        step(16'hF200, 1'b0, 8'h00);

        // Randomized mix
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                step(16'hF201, 1'b1, 8'($urandom));
            end else if (r < 8) begin
                step(16'hF200, 1'b1, 8'($urandom));
            end else if (r < 30) begin
                ra = 16'($urandom) & 16'h7FFF;
                step(ra, 1'b1, 8'($urandom));
            end else if (r < 60) begin
                ra = 16'($urandom) & 16'h7FFF;
                step(ra, 1'b0, 8'h00);
            end else if (r < 70) begin
                step(16'hF200, 1'b0, 8'h00);
            end else if (r < 75) begin
                step(16'hF201, 1'b0, 8'h00);
            end else begin
                step(16'($urandom), 1'b0, 8'h00);
            end
        end
        idle(900);
        step(16'hF200, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
